// File: rtl/sync_prefetch_fifo.sv
// sync_prefetch_fifo: single-clock first-word-fall-through FIFO, inferred dual-port RAM + prefetch register buffer.
// Latency: a write in cycle 0 on an empty FIFO shows rd_vld in cycle RAM_RD_LATENCY+2; streams one word per cycle.
// Backpressure: wr_vld drops while the RAM is full; rd_data holds while rd_vld & ~rd_en.
// Optional: define SYNC_PREFETCH_FIFO_ERR_FLAG_EN to add sticky ovf_err/udf_err outputs.
module sync_prefetch_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH_WIDTH    = 10,
  parameter int RAM_RD_LATENCY = 1,
  parameter int AFULL_THRESH   = (1 << DEPTH_WIDTH) - 4,
  parameter int AEMPTY_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  rd_vld,
  output logic [DEPTH_WIDTH:0]  level,
`ifdef SYNC_PREFETCH_FIFO_ERR_FLAG_EN
  output logic                  ovf_err,
  output logic                  udf_err,
`endif
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int PF_DEPTH = RAM_RD_LATENCY + 1;
  localparam int DEPTH    = 1 << DEPTH_WIDTH;
  localparam int CW       = DEPTH_WIDTH + 1;
  localparam int BCW      = 2;                 // prefetch buffer count, PF_DEPTH <= 3
  localparam int BIW      = $clog2(PF_DEPTH);  // prefetch buffer index
  localparam int OCW      = 3;                 // in-flight + buffered, at most 5

  localparam logic [CW-1:0] C_RAM_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] C_AEMPTY   = CW'(AEMPTY_THRESH);

  generate
    if (RAM_RD_LATENCY != 1 && RAM_RD_LATENCY != 2) begin : g_bad_latency
      $error("sync_prefetch_fifo: RAM_RD_LATENCY must be 1 or 2");
    end
  endgenerate

  // Storage and pointers
  logic [DATA_WIDTH-1:0]     r_mem [DEPTH];
  logic [DEPTH_WIDTH-1:0]    r_wr_ptr;
  logic [DEPTH_WIDTH-1:0]    r_rd_ptr;
  logic [CW-1:0]             r_ram_cnt;
  logic [RAM_RD_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0]     r_ram_q;
  logic [DATA_WIDTH-1:0]     r_buf [PF_DEPTH];
  logic [BCW-1:0]            r_buf_cnt;
  logic [CW-1:0]             r_level;

  logic                  w_wr_acc;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_ret;
  logic [DATA_WIDTH-1:0] w_ret_dat;
  logic [1:0]            w_inflight;
  logic [OCW-1:0]        w_occ;
  logic [BIW-1:0]        w_buf_widx;

  assign wr_vld   = ~rst & (r_ram_cnt != C_RAM_FULL);
  assign rd_vld   = (r_buf_cnt != '0);
  assign rd_data  = r_buf[0];
  assign w_wr_acc = wr_en & wr_vld;
  assign w_pop    = rd_en & rd_vld;
  assign w_ret    = r_pipe_vld[RAM_RD_LATENCY-1];

  // Count reads still travelling through the RAM pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RAM_RD_LATENCY; i++) begin
      w_inflight = w_inflight + 2'(r_pipe_vld[i]);
    end
  end

  // Only issue a read if every word already committed to the buffer still fits after this pop
  assign w_occ   = OCW'(w_inflight) + OCW'(r_buf_cnt);
  assign w_issue = (r_ram_cnt != '0) & (w_occ < (OCW'(PF_DEPTH) + OCW'(w_pop)));

  // Returning word lands just behind the entries that survive this cycle's pop
  assign w_buf_widx = BIW'(r_buf_cnt - BCW'(w_pop));

  // RAM write port
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  // RAM read port, first read register
  always_ff @(posedge clk) begin
    if (w_issue) r_ram_q <= r_mem[r_rd_ptr];
  end

  generate
    if (RAM_RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] r_ram_q2;
      // Second RAM output register stage
      always_ff @(posedge clk) begin
        r_ram_q2 <= r_ram_q;
      end
      assign w_ret_dat = r_ram_q2;
    end else begin : g_lat1
      assign w_ret_dat = r_ram_q;
    end
  endgenerate

  // Pointers, RAM occupancy and in-flight valid shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_pipe_vld <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
      if (w_issue)  r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
      r_ram_cnt  <= r_ram_cnt + CW'(w_wr_acc) - CW'(w_issue);
      r_pipe_vld <= RAM_RD_LATENCY'({r_pipe_vld, w_issue});
    end
  end

  // Prefetch buffer: head at index 0, shifts on pop, fills from the RAM pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PF_DEPTH; i++) r_buf[i] <= '0;
      r_buf_cnt <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < PF_DEPTH - 1; i++) r_buf[i] <= r_buf[i+1];
      end
      if (w_ret) r_buf[w_buf_widx] <= w_ret_dat;
      r_buf_cnt <= r_buf_cnt + BCW'(w_ret) - BCW'(w_pop);
    end
  end

  // Total occupancy across RAM, pipeline and buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= '0;
    end else if (w_wr_acc & ~w_pop) begin
      r_level <= r_level + CW'(1);
    end else if (~w_wr_acc & w_pop) begin
      r_level <= r_level - CW'(1);
    end
  end

  assign level        = r_level;
  assign almost_full  = (r_level >= C_AFULL);
  assign almost_empty = (r_level <= C_AEMPTY);

`ifdef SYNC_PREFETCH_FIFO_ERR_FLAG_EN
  logic r_ovf_err;
  logic r_udf_err;

  // Sticky misuse flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (wr_en & ~wr_vld) r_ovf_err <= 1'b1;
      if (rd_en & ~rd_vld) r_udf_err <= 1'b1;
    end
  end

  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;
`endif

endmodule
